// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared types and constants for the instruction loader.
//               Holds the loader state encoding, the default address/data
//               widths and the largest legal program length in words.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    localparam int ADDR_W_DEFAULT = 8;
    localparam int DATA_W_DEFAULT = 32;
    localparam int MAX_WORDS      = 256;
    localparam int LEN_W          = 9;    // width of load_len and word index

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage : loader_pkg
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_packer
// Description : Assembles a big-endian byte stream into DATA_W-bit words.
//               Byte k of a word lands in bits [DATA_W-1-8k -: 8].
// Ports       : clk        - clock
//               clr        - synchronous active-high reset
//               clear      - synchronous clear of byte counter and word
//               byte_en    - a byte transfers this cycle
//               byte_data  - the transferred byte
//               word       - assembled word including this cycle's byte
//               word_full  - this cycle's byte completes the word
// Revision    : 1.0 - initial release
// ============================================================================
module byte_packer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [7:0]        byte_data,
    output logic [DATA_W-1:0] word,
    output logic              word_full
);

    localparam int BYTES = DATA_W / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [CNT_W-1:0]  byte_cnt;
    logic [DATA_W-1:0] word_reg;

    // The word output already includes the byte arriving this cycle so the
    // loader can latch a complete word on the same edge as the last byte.
    always_comb begin
        word = word_reg;
        for (int k = 0; k < BYTES; k++) begin
            if (byte_en && (byte_cnt == CNT_W'(k))) begin
                word[DATA_W-1-8*k -: 8] = byte_data;
            end
        end
    end

    assign word_full = byte_en && (byte_cnt == CNT_W'(BYTES - 1));

    // Partial words persist for as long as byte_en stays low.
    always_ff @(posedge clk) begin
        if (clr || clear) begin
            byte_cnt <= '0;
            word_reg <= '0;
        end else if (byte_en) begin
            word_reg <= word;
            byte_cnt <= word_full ? '0 : byte_cnt + 1'b1;
        end
    end

endmodule : byte_packer
`default_nettype wire

// File: rtl/instruction_loader.sv
`default_nettype none
// ============================================================================
// Module      : instruction_loader
// Description : Loads a program byte stream into instruction memory, one
//               word write per four bytes, holding the CPU in clear until
//               the load completes.
// Ports       : clk, clr           - clock, synchronous active-high reset
//               load_start/len     - begin a load of load_len words
//               byte_valid/data    - incoming program bytes
//               byte_ready         - loader accepts a byte (RECV only)
//               imu_wen/addr/data  - instruction memory write port
//               cpu_clr            - high except when load is done
//               done               - load complete
//               err_len            - last request exceeded MAX_WORDS
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load_start,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imu_wen,
    output logic [ADDR_W-1:0] imu_addr,
    output logic [DATA_W-1:0] imu_data,
    output logic              cpu_clr,
    output logic              done,
    output logic              err_len
);

    state_t             state;
    logic [LEN_W-1:0]   word_idx;
    logic [LEN_W-1:0]   latched_len;

    logic               byte_en;
    logic               start_accept;
    logic               pack_clear;
    logic [DATA_W-1:0]  packed_word;
    logic               word_full;

    // byte_ready is high exactly while in RECV, so this is the handshake.
    assign byte_en      = byte_valid && byte_ready;
    assign start_accept = load_start && ((state == ST_IDLE) || (state == ST_DONE));
    assign pack_clear   = start_accept || (state == ST_WRITE);

    byte_packer #(
        .DATA_W (DATA_W)
    ) u_byte_packer (
        .clk       (clk),
        .clr       (clr),
        .clear     (pack_clear),
        .byte_en   (byte_en),
        .byte_data (byte_data),
        .word      (packed_word),
        .word_full (word_full)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= ST_IDLE;
            word_idx    <= '0;
            latched_len <= '0;
            byte_ready  <= 1'b0;
            imu_wen     <= 1'b0;
            imu_addr    <= '0;
            imu_data    <= '0;
            cpu_clr     <= 1'b1;
            done        <= 1'b0;
            err_len     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (load_start) begin
                        if (load_len > LEN_W'(MAX_WORDS)) begin
                            err_len <= 1'b1;
                            state   <= ST_IDLE;
                            done    <= 1'b0;
                            cpu_clr <= 1'b1;
                        end else if (load_len == '0) begin
                            // Empty program: nothing to write, finish at once.
                            err_len     <= 1'b0;
                            latched_len <= load_len;
                            state       <= ST_DONE;
                            done        <= 1'b1;
                            cpu_clr     <= 1'b0;
                        end else begin
                            err_len     <= 1'b0;
                            latched_len <= load_len;
                            word_idx    <= '0;
                            state       <= ST_RECV;
                            byte_ready  <= 1'b1;
                            done        <= 1'b0;
                            cpu_clr     <= 1'b1;
                        end
                    end
                end

                ST_RECV: begin
                    if (word_full) begin
                        state      <= ST_WRITE;
                        byte_ready <= 1'b0;
                        imu_wen    <= 1'b1;
                        imu_addr   <= ADDR_W'(word_idx);
                        imu_data   <= packed_word;
                    end
                end

                ST_WRITE: begin
                    imu_wen <= 1'b0;
                    if (word_idx == latched_len - 1'b1) begin
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        cpu_clr <= 1'b0;
                    end else begin
                        word_idx   <= word_idx + 1'b1;
                        state      <= ST_RECV;
                        byte_ready <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : instruction_loader
`default_nettype wire

// File: tb/tb_instruction_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_loader
// Description : Self-checking bench for instruction_loader. Expected memory
//               writes are queued as stimulus is issued; a monitor pops and
//               compares them whenever imu_wen is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_loader;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        load_start;
    logic [8:0]  load_len;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imu_wen;
    logic [7:0]  imu_addr;
    logic [31:0] imu_data;
    logic        cpu_clr;
    logic        done;
    logic        err_len;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_xfer_cyc = -10;
    wr_t exp_q[$];

    instruction_loader #(
        .ADDR_W (8),
        .DATA_W (32)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .load_start (load_start),
        .load_len   (load_len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imu_wen    (imu_wen),
        .imu_addr   (imu_addr),
        .imu_data   (imu_data),
        .cpu_clr    (cpu_clr),
        .done       (done),
        .err_len    (err_len)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (imu_wen === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {24'd0, imu_addr, imu_data}, 64'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(imu_addr), 64'(e.addr));
                    chk("wr_data", 64'(imu_data), 64'(e.data));
                    chk("wr_ready_low", 64'(byte_ready), 64'd0);
                    chk("wr_latency", 64'(cyc - last_xfer_cyc), 64'd0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [8:0] len);
        load_start = 1'b1;
        load_len   = len;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (byte_ready !== 1'b1) begin
            chk("byte_ready_timeout", 64'(byte_ready), 64'd1);
        end else begin
            tick();
            last_xfer_cyc = cyc;
        end
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[31-8*k -: 8]);
            repeat (gap) tick();
        end
    endtask

    task automatic push_exp(input logic [7:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(name, 64'(done), 64'd1);
        chk({name, "_cpu_clr"}, 64'(cpu_clr), 64'd0);
    endtask

    initial begin
        clr        = 1'b1;
        load_start = 1'b0;
        load_len   = '0;
        byte_valid = 1'b0;
        byte_data  = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_wen",   64'(imu_wen),    64'd0);
        chk("rst_addr",  64'(imu_addr),   64'd0);
        chk("rst_data",  64'(imu_data),   64'd0);
        chk("rst_cpu",   64'(cpu_clr),    64'd1);
        chk("rst_done",  64'(done),       64'd0);
        chk("rst_err",   64'(err_len),    64'd0);
        chk("rst_ready", 64'(byte_ready), 64'd0);
        clr = 1'b0;
        tick();

        // Single word
        start_load(9'd1);
        chk("t1_ready", 64'(byte_ready), 64'd1);
        push_exp(8'h00, 32'h2008_0005);
        send_word(32'h2008_0005, 0);
        wait_done("t1_done");
        repeat (2) tick();
        chk("t1_hold_data", 64'(imu_data), 64'h2008_0005);
        chk("t1_hold_addr", 64'(imu_addr), 64'h0);

        // Full memory
        start_load(9'd256);
        chk("t2_cpu_clr", 64'(cpu_clr), 64'd1);
        for (int n = 0; n < 256; n++) begin
            push_exp(8'(n), {4{8'(n)}});
            send_word({4{8'(n)}}, 0);
        end
        wait_done("t2_done");
        chk("t2_last_addr", 64'(imu_addr), 64'hFF);
        chk("t2_last_data", 64'(imu_data), 64'hFFFF_FFFF);
        chk("t2_sb_empty", 64'(exp_q.size()), 64'd0);

        // Stalls between every byte
        start_load(9'd2);
        push_exp(8'h00, 32'h1122_3344);
        push_exp(8'h01, 32'h5566_7788);
        send_word(32'h1122_3344, 3);
        send_word(32'h5566_7788, 3);
        wait_done("t3_done");

        // Length edge cases
        start_load(9'd0);
        chk("t4_len0_done", 64'(done), 64'd1);
        chk("t4_len0_cpu", 64'(cpu_clr), 64'd0);
        start_load(9'd300);
        chk("t4_err", 64'(err_len), 64'd1);
        chk("t4_err_cpu", 64'(cpu_clr), 64'd1);
        chk("t4_err_done", 64'(done), 64'd0);
        tick();
        chk("t4_err_idle_ready", 64'(byte_ready), 64'd0);
        chk("t4_err_stay", 64'(err_len), 64'd1);

        // Reset mid-load: after byte 2 of word 3 of 8
        start_load(9'd8);
        chk("t5_err_cleared", 64'(err_len), 64'd0);
        for (int n = 0; n < 3; n++) begin
            push_exp(8'(n), 32'hA0B0_C000 + 32'(n));
            send_word(32'hA0B0_C000 + 32'(n), 0);
        end
        send_byte(8'h99);
        send_byte(8'h98);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t5_wen",   64'(imu_wen),    64'd0);
        chk("t5_cpu",   64'(cpu_clr),    64'd1);
        chk("t5_done",  64'(done),       64'd0);
        chk("t5_ready", 64'(byte_ready), 64'd0);
        repeat (3) tick();
        chk("t5_no_resume", 64'(byte_ready), 64'd0);
        start_load(9'd1);
        push_exp(8'h00, 32'hDEAD_BEEF);
        send_word(32'hDEAD_BEEF, 0);
        wait_done("t5_done_after");

        // Reload from DONE
        start_load(9'd1);
        chk("t6_cpu_reassert", 64'(cpu_clr), 64'd1);
        chk("t6_done_clear", 64'(done), 64'd0);
        push_exp(8'h00, 32'hCAFE_F00D);
        send_word(32'hCAFE_F00D, 0);
        wait_done("t6_done");

        repeat (4) tick();
        chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_instruction_loader
`default_nettype wire

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter ADDR_W SHALL default to 8 and set the instruction-memory word-address width.
REQ-002 Parameter DATA_W SHALL default to 32 and set the instruction-word width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 clr  input  1  reset, synchronous and active-high.
REQ-005 load_start  input  1  one-cycle request to begin a program load.
REQ-006 load_len  input  9  number of words to load, sampled when load_start is accepted; valid range 0..256.
REQ-007 byte_valid  input  1  byte_data holds a valid program byte.
REQ-008 byte_data  input  8  program byte stream, big-endian within each word.
REQ-009 byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 imu_wen  output  1  active-high, one-cycle write strobe to instruction memory.
REQ-011 imu_addr  output  ADDR_W  word address of the current write.
REQ-012 imu_data  output  DATA_W  assembled instruction word.
REQ-013 cpu_clr  output  1  holds the processor datapath in clear while high.
REQ-014 done  output  1  program load has completed.
REQ-015 err_len  output  1  the last load_start had load_len > 256.

Function
REQ-016 States SHALL be IDLE, RECV, WRITE and DONE.
REQ-017 A byte SHALL transfer only in a cycle with byte_valid=1 and byte_ready=1.
REQ-018 byte_ready SHALL be 1 only in RECV.
REQ-019 In IDLE, load_start=1 with load_len in 1..256 SHALL cause these actions:
  - latch load_len;
  - clear the word index and byte counter;
  - clear err_len;
  - go to RECV.
REQ-020 In IDLE, load_start=1 with load_len=0 SHALL go to DONE with no writes.
REQ-021 In IDLE, load_start=1 with load_len>256 SHALL set err_len=1, remain in IDLE and perform no writes.
REQ-022 In RECV, each transfer SHALL place byte k (k=0..3) of the current word into bits [31-8k : 24-8k], with byte 0 going to [31:24].
REQ-023 The cycle after the 4th byte of a word transfers, the state SHALL be WRITE.
REQ-024 In WRITE, imu_wen SHALL be 1 for exactly that cycle, with imu_addr = word index and imu_data = assembled word.
REQ-025 Latency SHALL be exactly one cycle from the 4th byte transfer to the imu_wen pulse.
REQ-026 From WRITE:
  - if word index = latched length - 1, the next state SHALL be DONE;
  - otherwise the word index SHALL increment, the byte counter SHALL clear, and the next state SHALL be RECV.
REQ-027 The word index SHALL be 9 bits wide; imu_addr SHALL be its low ADDR_W bits, so word 255 writes address 0xFF and the index never wraps within a legal load.
REQ-028 byte_valid gaps SHALL stall assembly without loss; partial-word bytes SHALL be retained indefinitely.
REQ-029 load_start in RECV or WRITE SHALL be ignored.
REQ-030 In DONE:
  - done SHALL be 1 and cpu_clr SHALL be 0;
  - load_start SHALL be evaluated exactly as in IDLE, reasserting cpu_clr and clearing done when a new load is accepted.
REQ-031 cpu_clr SHALL be 1 in every state except DONE.
REQ-032 imu_wen SHALL be 0 outside WRITE.
REQ-033 imu_data and imu_addr SHALL hold their last values while imu_wen=0.

Reset
REQ-034 clr=1 SHALL force the following on the next edge, overriding every other input including mid-load:
  - state IDLE;
  - word index, byte counter, latched length, imu_addr and imu_data all 0;
  - imu_wen=0, byte_ready=0, done=0, err_len=0;
  - cpu_clr=1.
REQ-035 A load interrupted by clr SHALL NOT resume; a new load_start SHALL be required.

Structure
REQ-036 A shared package loader_pkg SHALL hold:
  - the state enum;
  - ADDR_W and DATA_W defaults;
  - MAX_WORDS=256.
REQ-037 A sub-module byte_packer SHALL perform the 4-byte-to-word assembly and byte counting, reporting word_full; the state machine and indexing SHALL stay in instruction_loader.

Verification
REQ-038 Single word: clr released, load_start with load_len=1, bytes 0x20,0x08,0x00,0x05 on consecutive cycles. Required response:
  - one imu_wen pulse with addr 0x00 and data 0x20080005, one cycle after the last byte;
  - then done=1 and cpu_clr=0.
REQ-039 Full memory: load_len=256 with word n = n replicated in all 4 bytes. Required response:
  - 256 pulses, the last at addr 0xFF with data 0xFFFFFFFF;
  - done=1 and no addr wrap.
REQ-040 Stalls: load_len=2 with byte_valid deasserted 3 cycles between every byte. Required response:
  - data words 0x11223344 and 0x55667788 at addrs 0 and 1;
  - byte_ready=0 during WRITE.
REQ-041 Length edge cases:
  - load_len=0 -> done=1 within 2 cycles and no imu_wen;
  - load_len=300 -> err_len=1, state stays IDLE, cpu_clr=1.
REQ-042 Reset mid-load: clr asserted after byte 2 of word 3 of 8. Required response:
  - next cycle imu_wen=0, cpu_clr=1, done=0, byte_ready=0;
  - a fresh load_len=1 load then writes addr 0 correctly.
REQ-043 Reload: in DONE, load_start with load_len=1. Required response:
  - cpu_clr reasserts the next cycle and done clears;
  - the new word is written to addr 0.
